rfft_pe_pipe: RTL

//  Parametrised radix-2 real-FFT processing element: two butterflies plus a complex twiddle multiply.

---
 rtl/rfft_pe_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rfft_pe_pipe.sv
// Radix-2 real-FFT processing element: two input butterflies followed by a
// complex twiddle multiply on the difference terms. Four-stage pipeline with
// valid/ready flow control; a stalled output freezes every stage, bubbles included.
module rfft_pe_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DATA_W-1:0]   in1,
  input  logic [DATA_W-1:0]   in2,
  input  logic [DATA_W-1:0]   in3,
  input  logic [2*TW_W-1:0]   tf,
  input  logic                bypass_n,
  input  logic                inverse,
  input  logic                scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out0,
  output logic [DATA_W-1:0]   out1,
  output logic [DATA_W-1:0]   out2,
  output logic [DATA_W-1:0]   out3,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int BW = DATA_W + 1;          // butterfly width
  localparam int PW = DATA_W + TW_W + 1;   // product width
  localparam int SW = PW + 1;              // sum width, holds a+b of two products

  localparam logic signed [TW_W-1:0] TMAX = {1'b0, {(TW_W-1){1'b1}}};
  localparam logic signed [TW_W-1:0] TMIN = {1'b1, {(TW_W-1){1'b0}}};
  localparam logic signed [SW-1:0]   HI   = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0]   LO   = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0]   RND  = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};

  // Optional halving with round-half-up: (v+1)>>>1, done one bit wider so +1 cannot wrap.
  function automatic logic signed [BW-1:0] halve(input logic signed [BW-1:0] v, input logic scl);
    logic signed [BW:0] t;
    t = {v[BW-1], v} + (BW+1)'(1);
    return scl ? t[BW:1] : v;
  endfunction

  // Clamp to DATA_W signed range; MSB of the result flags that clamping happened.
  function automatic logic [DATA_W:0] sat(input logic signed [SW-1:0] v);
    if (v > HI)      return {1'b1, HI[DATA_W-1:0]};
    else if (v < LO) return {1'b1, LO[DATA_W-1:0]};
    else             return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic       adv, acc;
  logic [4:1] vld_pipe;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign acc       = in_valid && adv;
  assign out_valid = vld_pipe[4];

  // Valid shift register; holds (bubbles too) while downstream stalls.
  always_ff @(posedge Clk) begin
    if (!Reset_n)  vld_pipe <= '0;
    else if (adv)  vld_pipe <= {vld_pipe[3:1], acc};
  end

  // ---------------- S1: butterflies + optional halving ----------------
  logic signed [BW-1:0]   x0, x1, x2, x3;
  logic signed [BW-1:0]   s1_a0, s1_a1, s1_b0, s1_b1;
  logic signed [TW_W-1:0] s1_tr, s1_ti;
  logic                   s1_inv, s1_byp;

  assign x0 = {in0[DATA_W-1], in0};
  assign x1 = {in1[DATA_W-1], in1};
  assign x2 = {in2[DATA_W-1], in2};
  assign x3 = {in3[DATA_W-1], in3};

  // Capture butterflies and the sideband that later stages still need.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_a0 <= '0; s1_a1 <= '0; s1_b0 <= '0; s1_b1 <= '0;
      s1_tr <= '0; s1_ti <= '0; s1_inv <= 1'b0; s1_byp <= 1'b0;
    end else if (adv) begin
      s1_a0  <= halve(x0 + x1, scale);
      s1_a1  <= halve(x0 - x1, scale);
      s1_b0  <= halve(x2 + x3, scale);
      s1_b1  <= halve(x2 - x3, scale);
      s1_tr  <= tf[2*TW_W-1:TW_W];
      s1_ti  <= tf[TW_W-1:0];
      s1_inv <= inverse;
      s1_byp <= bypass_n;
    end
  end

  // ---------------- S2: twiddle products ----------------
  logic signed [TW_W-1:0] tip;
  logic signed [BW-1:0]   s2_a0, s2_a1, s2_b0, s2_b1;
  logic signed [PW-1:0]   s2_p_ar, s2_p_bi, s2_p_ai, s2_p_br;
  logic                   s2_byp;

  // Conjugate twiddle for inverse; negating the most negative value clamps to +max.
  always_comb begin
    tip = s1_ti;
    if (s1_inv) tip = (s1_ti == TMIN) ? TMAX : -s1_ti;
  end

  // Four partial products of (a1 + j*b1) * (tr + j*ti').
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2_a0 <= '0; s2_a1 <= '0; s2_b0 <= '0; s2_b1 <= '0;
      s2_p_ar <= '0; s2_p_bi <= '0; s2_p_ai <= '0; s2_p_br <= '0;
      s2_byp <= 1'b0;
    end else if (adv) begin
      s2_a0   <= s1_a0; s2_a1 <= s1_a1; s2_b0 <= s1_b0; s2_b1 <= s1_b1;
      s2_p_ar <= PW'(s1_a1) * PW'(s1_tr);
      s2_p_bi <= PW'(s1_b1) * PW'(tip);
      s2_p_ai <= PW'(s1_a1) * PW'(tip);
      s2_p_br <= PW'(s1_b1) * PW'(s1_tr);
      s2_byp  <= s1_byp;
    end
  end

  // ---------------- S3: complex sums ----------------
  logic signed [BW-1:0] s3_a0, s3_a1, s3_b0, s3_b1;
  logic signed [SW-1:0] s3_re, s3_im;
  logic                 s3_byp;

  // Real and imaginary parts at full precision.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s3_a0 <= '0; s3_a1 <= '0; s3_b0 <= '0; s3_b1 <= '0;
      s3_re <= '0; s3_im <= '0; s3_byp <= 1'b0;
    end else if (adv) begin
      s3_a0  <= s2_a0; s3_a1 <= s2_a1; s3_b0 <= s2_b0; s3_b1 <= s2_b1;
      s3_re  <= SW'(s2_p_ar) - SW'(s2_p_bi);
      s3_im  <= SW'(s2_p_ai) + SW'(s2_p_br);
      s3_byp <= s2_byp;
    end
  end

  // ---------------- S4: round, saturate, select ----------------
  logic signed [SW-1:0] re_sh, im_sh;
  logic [DATA_W:0]      q0, q1, q2, q3;
  logic                 any_sat;

  // Drop the Q1.(TW_W-1) fraction with round-half-up, then clamp every output.
  always_comb begin
    re_sh   = (s3_re + RND) >>> (TW_W-1);
    im_sh   = (s3_im + RND) >>> (TW_W-1);
    q0      = sat(SW'(s3_a0));
    q1      = sat(SW'(s3_b0));
    q2      = s3_byp ? sat(re_sh) : sat(SW'(s3_a1));
    q3      = s3_byp ? sat(im_sh) : sat(SW'(s3_b1));
    any_sat = q0[DATA_W] | q1[DATA_W] | q2[DATA_W] | q3[DATA_W];
  end

  // Output register; held stable while downstream is not ready.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out0 <= '0; out1 <= '0; out2 <= '0; out3 <= '0;
    end else if (adv) begin
      out0 <= q0[DATA_W-1:0];
      out1 <= q1[DATA_W-1:0];
      out2 <= q2[DATA_W-1:0];
      out3 <= q3[DATA_W-1:0];
    end
  end

  // Sticky overflow: a real set entering the output register wins over a clear.
  always_ff @(posedge Clk) begin
    if (!Reset_n)                          ovf <= 1'b0;
    else if (adv && vld_pipe[3] && any_sat) ovf <= 1'b1;
    else if (ovf_clr)                      ovf <= 1'b0;
  end

endmodule
